// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter CSR block.
// Contents: event selector encoding, CSR address constants and the
// event-qualification helper used by the programmable counters.
package perf_pkg;

  typedef enum logic [4:0] {
    EV_NONE          = 5'd0,
    EV_LOAD_STALL    = 5'd1,
    EV_MISPREDICT    = 5'd2,
    EV_IC_MISS_START = 5'd3,
    EV_IC_MISS_CYCLE = 5'd4
  } perf_event_e;

  localparam logic [11:0] MCYCLE_ADDR        = 12'hB00;
  localparam logic [11:0] MCYCLEH_ADDR       = 12'hB80;
  localparam logic [11:0] MINSTRET_ADDR      = 12'hB02;
  localparam logic [11:0] MINSTRETH_ADDR     = 12'hB82;
  localparam logic [11:0] MHPMCNT_BASE       = 12'hB00;
  localparam logic [11:0] MHPMCNTH_BASE      = 12'hB80;
  localparam logic [11:0] MHPMEVT_BASE       = 12'h320;
  localparam logic [11:0] MCOUNTINHIBIT_ADDR = 12'h320;
  localparam logic [11:0] CYCLE_ADDR         = 12'hC00;
  localparam logic [11:0] CYCLEH_ADDR        = 12'hC80;
  localparam logic [11:0] INSTRET_ADDR       = 12'hC02;
  localparam logic [11:0] INSTRETH_ADDR      = 12'hC82;
  localparam logic [11:0] HPMCNT_BASE        = 12'hC00;

  // Counter spaces (Bxx/Cxx): bits [11:8] and [6:5] fixed, bit 7 = high half, [4:0] = index.
  localparam logic [11:0] CNT_SPACE_MASK     = 12'hF60;
  // Event space (320..33F): index in [4:0].
  localparam logic [11:0] EVT_SPACE_MASK     = 12'hFE0;

  localparam int unsigned HPM_FIRST = 3;

  // Unlisted selector codes never fire.
  function automatic logic event_fires(input logic [4:0] code,
                                       input logic       load_stall,
                                       input logic       mispredict,
                                       input logic       miss_start,
                                       input logic       miss_cycle);
    logic fire;
    fire = 1'b0;
    case (perf_event_e'(code))
      EV_LOAD_STALL:    fire = load_stall;
      EV_MISPREDICT:    fire = mispredict;
      EV_IC_MISS_START: fire = miss_start;
      EV_IC_MISS_CYCLE: fire = miss_cycle;
      default:          fire = 1'b0;
    endcase
    return fire;
  endfunction

endpackage

// File: rtl/perf_counter64.sv
// One CNT_W-bit performance counter with 32-bit half writes.
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   inc_i, inhibit_i     count request and its inhibit
//   wr_lo_i, wr_hi_i     write low / high 32-bit half from wdata_i
//   wdata_i              write data
//   cnt_o                registered count
// A write to either half suppresses the increment for that cycle; the
// unwritten half is held. CNT_W must lie in 33..64.
module perf_counter64 #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             inhibit_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]       = wdata_i;
      if (wr_hi_i) cnt_d[CNT_W-1:32] = wdata_i[CNT_W-33:0];
    end else if (inc_i && !inhibit_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_counter_csr.sv
// RV32 Zicntr/Zihpm performance counters exposed as CSRs.
// Reads decode the EX-stage address combinationally and return registered
// state; writes commit from WB.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   csr_raddr_ex_i          read address; csr_rdata_ex_o / csr_hit_ex_o result
//   csr_we_wb_i, csr_waddr_wb_i, csr_wdata_wb_i   write port
//   valid_wb_i, stall_wb_i  retire = valid & ~stall
//   load_stall_i, pc_src_i, flush_ex_i, instr_hit_fi_i   event sources
// Build option: PERF_HPM_EN enables NUM_HPM programmable counters/events.
// Without it only mcycle/minstret exist; mhpm* addresses hit and read zero.
module perf_counter_csr
  import perf_pkg::*;
#(
  parameter int unsigned NUM_HPM = 4,
  parameter int unsigned CNT_W   = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [11:0] csr_raddr_ex_i,
  output logic [31:0] csr_rdata_ex_o,
  output logic        csr_hit_ex_o,
  input  logic        csr_we_wb_i,
  input  logic [11:0] csr_waddr_wb_i,
  input  logic [31:0] csr_wdata_wb_i,
  input  logic        valid_wb_i,
  input  logic        stall_wb_i,
  input  logic        load_stall_i,
  input  logic [1:0]  pc_src_i,
  input  logic        flush_ex_i,
  input  logic        instr_hit_fi_i
);

`ifdef PERF_HPM_EN
  localparam int unsigned NUM_CNT      = 2 + NUM_HPM;
  localparam logic [31:0] INHIBIT_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << HPM_FIRST);
`else
  localparam int unsigned NUM_CNT      = 2;
  localparam logic [31:0] INHIBIT_MASK = 32'h5;
`endif

  // Slot 0 = mcycle, slot 1 = minstret, slot 2+k = mhpmcounter(3+k).
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [NUM_CNT-1:0] inc, inhibit, wr_lo, wr_hi;
  logic [31:0]        mcountinhibit_q, mcountinhibit_d;
  logic               retire;
  logic [4:0]         widx, ridx;
  logic [CNT_W-1:0]   sel;

  assign retire = valid_wb_i & ~stall_wb_i;
  assign widx   = csr_waddr_wb_i[4:0];
  assign ridx   = csr_raddr_ex_i[4:0];

`ifdef PERF_HPM_EN
  logic [4:0] mhpmevent_q [NUM_HPM];
  logic [4:0] mhpmevent_d [NUM_HPM];
  logic       prev_hit_q, prev_hit_d;
  logic       mispredict, miss_start, miss_cycle;

  assign mispredict = flush_ex_i & (pc_src_i != 2'b00);
  // prev_hit resets to 1 so a miss on the first cycle after reset counts as a start.
  assign miss_start = prev_hit_q & ~instr_hit_fi_i;
  assign miss_cycle = ~instr_hit_fi_i;
  assign prev_hit_d = instr_hit_fi_i;
`else
  logic unused_event_inputs;
  assign unused_event_inputs = ^{load_stall_i, pc_src_i, flush_ex_i, instr_hit_fi_i};
`endif

  // Write decode: only the machine (Bxx) counter space and the 32x event space.
  always_comb begin
    wr_lo           = '0;
    wr_hi           = '0;
    mcountinhibit_d = mcountinhibit_q;
`ifdef PERF_HPM_EN
    mhpmevent_d     = mhpmevent_q;
`endif
    if (csr_we_wb_i && ((csr_waddr_wb_i & CNT_SPACE_MASK) == MHPMCNT_BASE)) begin
      if (widx == 5'd0) begin
        wr_lo[0] = ~csr_waddr_wb_i[7];
        wr_hi[0] =  csr_waddr_wb_i[7];
      end
      if (widx == 5'd2) begin
        wr_lo[1] = ~csr_waddr_wb_i[7];
        wr_hi[1] =  csr_waddr_wb_i[7];
      end
`ifdef PERF_HPM_EN
      for (int unsigned k = 0; k < NUM_HPM; k++) begin
        if (widx == 5'(HPM_FIRST + k)) begin
          wr_lo[2+k] = ~csr_waddr_wb_i[7];
          wr_hi[2+k] =  csr_waddr_wb_i[7];
        end
      end
`endif
    end
    if (csr_we_wb_i && ((csr_waddr_wb_i & EVT_SPACE_MASK) == MHPMEVT_BASE)) begin
      if (widx == 5'd0) mcountinhibit_d = csr_wdata_wb_i & INHIBIT_MASK;
`ifdef PERF_HPM_EN
      for (int unsigned k = 0; k < NUM_HPM; k++) begin
        if (widx == 5'(HPM_FIRST + k)) mhpmevent_d[k] = csr_wdata_wb_i[4:0];
      end
`endif
    end
  end

  always_comb begin
    inc        = '0;
    inhibit    = '0;
    inc[0]     = 1'b1;
    inhibit[0] = mcountinhibit_q[0];
    inc[1]     = retire;
    inhibit[1] = mcountinhibit_q[2];
`ifdef PERF_HPM_EN
    for (int unsigned k = 0; k < NUM_HPM; k++) begin
      inc[2+k]     = event_fires(mhpmevent_q[k], load_stall_i, mispredict, miss_start, miss_cycle);
      inhibit[2+k] = mcountinhibit_q[HPM_FIRST+k];
    end
`endif
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_counter64 #(.CNT_W(CNT_W)) u_cnt (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .inc_i     (inc[g]),
      .inhibit_i (inhibit[g]),
      .wr_lo_i   (wr_lo[g]),
      .wr_hi_i   (wr_hi[g]),
      .wdata_i   (csr_wdata_wb_i),
      .cnt_o     (cnt[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcountinhibit_q <= '0;
`ifdef PERF_HPM_EN
      prev_hit_q      <= 1'b1;
      for (int unsigned k = 0; k < NUM_HPM; k++) mhpmevent_q[k] <= '0;
`endif
    end else begin
      mcountinhibit_q <= mcountinhibit_d;
`ifdef PERF_HPM_EN
      prev_hit_q      <= prev_hit_d;
      mhpmevent_q     <= mhpmevent_d;
`endif
    end
  end

  // Read decode. Index 1 (time) is not ours; counter/event indices 3..31
  // beyond the implemented set are architecturally legal and read zero.
  always_comb begin
    csr_hit_ex_o   = 1'b0;
    csr_rdata_ex_o = '0;
    sel            = '0;
    if (((csr_raddr_ex_i & CNT_SPACE_MASK) == MHPMCNT_BASE) ||
        ((csr_raddr_ex_i & CNT_SPACE_MASK) == HPMCNT_BASE)) begin
      if (ridx != 5'd1) begin
        csr_hit_ex_o = 1'b1;
        if (ridx == 5'd0) sel = cnt[0];
        if (ridx == 5'd2) sel = cnt[1];
`ifdef PERF_HPM_EN
        for (int unsigned k = 0; k < NUM_HPM; k++) begin
          if (ridx == 5'(HPM_FIRST + k)) sel = cnt[2+k];
        end
`endif
        csr_rdata_ex_o = csr_raddr_ex_i[7] ? 32'(sel >> 32) : sel[31:0];
      end
    end else if ((csr_raddr_ex_i & EVT_SPACE_MASK) == MHPMEVT_BASE) begin
      if (ridx == 5'd0) begin
        csr_hit_ex_o   = 1'b1;
        csr_rdata_ex_o = mcountinhibit_q;
      end else if (ridx >= 5'd3) begin
        csr_hit_ex_o = 1'b1;
`ifdef PERF_HPM_EN
        for (int unsigned k = 0; k < NUM_HPM; k++) begin
          if (ridx == 5'(HPM_FIRST + k)) csr_rdata_ex_o = {27'b0, mhpmevent_q[k]};
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_csr.sv
// Bench for perf_counter_csr: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a CSR-level model.
module tb_perf_counter_csr;

  localparam int unsigned NUM_HPM = 4;
`ifdef PERF_HPM_EN
  localparam bit HPM_EN = 1'b1;
`else
  localparam bit HPM_EN = 1'b0;
`endif

  logic        clk, reset;
  logic [11:0] raddr, waddr;
  logic [31:0] rdata, wdata;
  logic        hit, we, valid, stall, load_stall, flush, instr_hit;
  logic [1:0]  pc_src;

  perf_counter_csr #(.NUM_HPM(NUM_HPM), .CNT_W(64)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .csr_raddr_ex_i (raddr),
    .csr_rdata_ex_o (rdata),
    .csr_hit_ex_o   (hit),
    .csr_we_wb_i    (we),
    .csr_waddr_wb_i (waddr),
    .csr_wdata_wb_i (wdata),
    .valid_wb_i     (valid),
    .stall_wb_i     (stall),
    .load_stall_i   (load_stall),
    .pc_src_i       (pc_src),
    .flush_ex_i     (flush),
    .instr_hit_fi_i (instr_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Model state indexed by CSR counter index (0 cycle, 2 instret, 3..31 hpm).
  longint unsigned m_cnt [32];
  logic [4:0]      m_evt [32];
  logic [31:0]     m_inh;
  bit              m_prev_hit;
  bit              m_ready = 1'b0;

  function automatic bit impl(input int idx);
    return (idx == 0) || (idx == 2) || (HPM_EN && idx >= 3 && idx < 3 + NUM_HPM);
  endfunction

  function automatic logic [31:0] inh_mask();
    logic [31:0] m;
    m = 32'h5;
    if (HPM_EN) m = m | (((32'd1 << NUM_HPM) - 32'd1) << 3);
    return m;
  endfunction

  function automatic void model_read(input logic [11:0] a, output bit h, output logic [31:0] d);
    int idx;
    longint unsigned v;
    idx = int'(a[4:0]);
    h = 1'b0;
    d = '0;
    if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00 && idx != 1) begin
      h = 1'b1;
      v = m_cnt[idx];
      d = a[7] ? v[63:32] : v[31:0];
    end else if (a[11:8] == 4'h3 && a[7:5] == 3'b001) begin
      if (idx == 0) begin
        h = 1'b1;
        d = m_inh;
      end else if (idx >= 3) begin
        h = 1'b1;
        d = {27'b0, m_evt[idx]};
      end
    end
  endfunction

  function automatic bit ev_fire(input logic [4:0] code);
    case (code)
      5'd1:    return load_stall;
      5'd2:    return flush && (pc_src != 2'b00);
      5'd3:    return m_prev_hit && !instr_hit;
      5'd4:    return !instr_hit;
      default: return 1'b0;
    endcase
  endfunction

  bit              fire    [32];
  bit              written [32];
  longint unsigned tmp;

  always @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 32; n++) begin
        m_cnt[n] = 0;
        m_evt[n] = '0;
      end
      m_inh      = '0;
      m_prev_hit = 1'b1;
      m_ready    = 1'b1;
    end else begin
      for (int n = 0; n < 32; n++) begin
        fire[n]    = (n >= 3) && impl(n) && ev_fire(m_evt[n]);
        written[n] = 1'b0;
      end
      fire[0] = 1'b1;
      fire[2] = valid && !stall;
      if (we && waddr[11:8] == 4'hB && waddr[6:5] == 2'b00 && impl(int'(waddr[4:0]))) begin
        tmp = m_cnt[waddr[4:0]];
        if (waddr[7]) tmp[63:32] = wdata;
        else          tmp[31:0]  = wdata;
        m_cnt[waddr[4:0]]   = tmp;
        written[waddr[4:0]] = 1'b1;
      end
      for (int n = 0; n < 32; n++)
        if (!written[n] && fire[n] && !m_inh[n]) m_cnt[n] = m_cnt[n] + 1;
      if (we && waddr[11:8] == 4'h3 && waddr[7:5] == 3'b001) begin
        if (waddr[4:0] == 5'd0) m_inh = wdata & inh_mask();
        else if (waddr[4:0] >= 5'd3 && impl(int'(waddr[4:0]))) m_evt[waddr[4:0]] = wdata[4:0];
      end
      m_prev_hit = instr_hit;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit          eh;
    logic [31:0] ed;
    if (m_ready) begin
      model_read(raddr, eh, ed);
      vectors++;
      if (hit !== eh || rdata !== ed) begin
        miscompares++;
        $display("FAIL cycle_read t=%0t addr=%h: dut hit=%0b data=%h, model hit=%0b data=%h",
                 $time, raddr, hit, rdata, eh, ed);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  // Literal expectation: both the DUT and the model must agree with it.
  task automatic check_lit(input string name, input logic [11:0] a,
                           input logic exp_h, input logic [31:0] exp_d);
    bit          mh;
    logic [31:0] md;
    raddr = a;
    #1;
    model_read(a, mh, md);
    vectors++;
    if (hit !== exp_h || rdata !== exp_d || mh != exp_h || md !== exp_d) begin
      miscompares++;
      $display("FAIL %s addr=%h: dut hit=%0b data=%h model hit=%0b data=%h, expected hit=%0b data=%h",
               name, a, hit, rdata, mh, md, exp_h, exp_d);
    end
  endtask

  localparam logic [11:0] ADDRS [0:30] = '{
    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB84,
    12'hB05, 12'hB85, 12'hB06, 12'hB86, 12'hB07, 12'hB1F, 12'h320, 12'h321,
    12'h322, 12'h323, 12'h324, 12'h325, 12'h326, 12'h327, 12'h33F, 12'hC00,
    12'hC80, 12'hC02, 12'hC03, 12'hC86, 12'h7C0, 12'hB01, 12'hF11
  };

  int unsigned retires;

  initial begin
    reset = 1'b1; raddr = 12'hB00; waddr = '0; wdata = '0; we = 1'b0;
    valid = 1'b0; stall = 1'b0; load_stall = 1'b0; flush = 1'b0;
    pc_src = 2'b00; instr_hit = 1'b1;
    tick();
    tick();
    check_lit("reset_mcycle", 12'hB00, 1'b1, 32'h0);
    reset = 1'b0;

    // 100 counting cycles with random retirement.
    retires = 0;
    for (int i = 0; i < 100; i++) begin
      valid = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      if (valid && !stall) retires++;
      tick();
    end
    valid = 1'b0;
    stall = 1'b0;
    check_lit("mcycle_100", 12'hB00, 1'b1, 32'd100);
    check_lit("mcycleh_100", 12'hB80, 1'b1, 32'd0);
    check_lit("minstret_count", 12'hB02, 1'b1, retires);
    check_lit("hpm3_zero", 12'hB03, 1'b1, 32'd0);

    // Low-half carry into the high half.
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'h0);
    check_lit("mcycle_after_hi_write", 12'hB00, 1'b1, 32'hFFFF_FFFE);
    tick();
    tick();
    check_lit("mcycle_wrap_lo", 12'hB00, 1'b1, 32'h0);
    check_lit("mcycle_wrap_hi", 12'hB80, 1'b1, 32'h1);

    // Load-stall event on hpm3, hpm4 left on event 0.
    wr(12'h323, 32'h1);
    wr(12'h324, 32'h0);
    load_stall = 1'b1;
    repeat (7) tick();
    load_stall = 1'b0;
    check_lit("hpm3_load_stall", 12'hB03, 1'b1, HPM_EN ? 32'd7 : 32'd0);
    check_lit("hpm4_event0", 12'hB04, 1'b1, 32'd0);
    check_lit("mhpmevent3", 12'h323, 1'b1, HPM_EN ? 32'd1 : 32'd0);

    // Inhibit: WARL mask, freeze, resume. mcycle is 0x1_0000_0009 before.
    wr(12'h320, 32'hFFFF_FFFF);
    check_lit("inhibit_warl", 12'h320, 1'b1, HPM_EN ? 32'h7D : 32'h5);
    wr(12'h320, 32'h5);
    for (int i = 0; i < 20; i++) begin
      valid = 1'($urandom_range(0, 1));
      tick();
    end
    valid = 1'b0;
    check_lit("mcycle_frozen", 12'hB00, 1'b1, 32'hA);
    check_lit("minstret_frozen", 12'hB02, 1'b1, retires);
    wr(12'h320, 32'h0);
    valid = 1'b1;
    repeat (3) tick();
    valid = 1'b0;
    check_lit("mcycle_resumed", 12'hB00, 1'b1, 32'hD);
    check_lit("minstret_resumed", 12'hB02, 1'b1, retires + 3);

    // Write wins over a same-cycle retire.
    valid = 1'b1;
    wr(12'hB02, 32'h10);
    valid = 1'b0;
    check_lit("minstret_write_wins", 12'hB02, 1'b1, 32'h10);

    // User aliases and unmapped addresses.
    check_lit("cycle_alias", 12'hC00, 1'b1, 32'hE);
    wr(12'hC00, 32'h55);
    check_lit("cycle_alias_ro", 12'hB00, 1'b1, 32'hF);
    check_lit("unmapped_7c0", 12'h7C0, 1'b0, 32'h0);
    check_lit("unmapped_b01", 12'hB01, 1'b0, 32'h0);
    check_lit("hpm31_zero", 12'hB1F, 1'b1, 32'h0);
    check_lit("hpmcounter3_alias", 12'hC03, 1'b1, HPM_EN ? 32'd7 : 32'd0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      valid      = 1'($urandom_range(0, 1));
      stall      = 1'($urandom_range(0, 1));
      load_stall = 1'($urandom_range(0, 1));
      flush      = 1'($urandom_range(0, 1));
      pc_src     = 2'($urandom_range(0, 3));
      instr_hit  = ($urandom_range(0, 3) != 0);
      we         = ($urandom_range(0, 3) == 0);
      waddr      = ADDRS[$urandom_range(0, 30)];
      case ($urandom_range(0, 3))
        0:       wdata = 32'hFFFF_FFFF - $urandom_range(0, 3);
        1:       wdata = $urandom;
        2:       wdata = 32'($urandom_range(0, 7));
        default: wdata = 32'h0;
      endcase
      raddr = ADDRS[$urandom_range(0, 30)];
      tick();
    end
    reset = 1'b0;
    we    = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
